uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
Command sequencer behind the UART receiver on the debug path of the MIPS FPGA design.
- Consumes the receiver's byte stream (data byte plus one-cycle done tick).
- Decodes one-byte commands.
- For LOAD, assembles little-endian 32-bit words and writes them to instruction memory at consecutive word addresses.
- Drives the processor run level and the single-step pulse.

Parameters:
- ADDR_W, 10, instruction memory word-address width.
- TIMEOUT_CYCLES, 2000000, maximum clock cycles allowed between bytes inside a LOAD frame.
- CMD_LOAD, 8'h01, command byte that starts a program load.
- CMD_RUN, 8'h02, command byte that sets run.
- CMD_STEP, 8'h03, command byte that issues one step pulse.
- CMD_HALT, 8'h04, command byte that clears run.

Ports:
- clock  in  1  system clock; single clock domain.
- reset_i  in  1  synchronous, active-high reset.
- rx_done_tick_i  in  1  one-cycle strobe: rx_data_i holds a valid byte.
- rx_data_i  in  8  received byte.
- imem_we_o  out  1  instruction memory write enable, one cycle per word.
- imem_addr_o  out  ADDR_W  instruction memory word address.
- imem_wdata_o  out  32  instruction word.
- run_o  out  1  processor free-run enable (level).
- step_o  out  1  one-cycle single-step pulse.
- busy_o  out  1  high while a LOAD frame is in progress.
- load_done_o  out  1  one-cycle pulse when a LOAD completes.
- err_o  out  1  sticky error flag; cleared when the next valid command byte is accepted.

Behaviour:
- All state updates on posedge clock. reset_i has priority over every other input.
- Reset values: all outputs 0, state IDLE, all counters 0.
- Reset mid-LOAD aborts the frame. Words already written stay in memory; nothing further is written.
- States:
  - IDLE: on tick, decode rx_data_i.
    - LOAD: run_o<=0, go LEN_LO.
    - RUN: run_o<=1.
    - STEP: step_o=1 next cycle, only if run_o=0; otherwise ignored.
    - HALT: run_o<=0.
    - Any other byte: err_o<=1, stay IDLE.
  - LEN_LO: on tick, latch count[7:0], go LEN_HI.
  - LEN_HI: on tick, latch count[15:8] and clear word address and byte index.
    - count==0: load_done_o pulse next cycle, go IDLE.
    - Otherwise: go DATA.
  - DATA: on tick, shift the byte into the word assembler at lane byte_idx (byte 0 -> bits[7:0]); byte_idx increments modulo 4.
    - When byte_idx==3: the next cycle has imem_we_o=1, imem_wdata_o=assembled word, imem_addr_o=current address. The address then increments modulo 2^ADDR_W (wrap allowed, no error). Words-remaining decrements.
    - When the last word's write is issued: load_done_o pulses in that same cycle, state goes IDLE.
- busy_o = 1 in LEN_LO, LEN_HI and DATA.
- Timeout: a gap counter clears on every tick and on entry to LEN_LO, and increments each cycle in LEN_LO, LEN_HI and DATA. If it reaches TIMEOUT_CYCLES: err_o<=1, go IDLE, no partial-word write.
- Write latency: exactly 1 cycle from the 4th byte's tick to imem_we_o.
- imem_addr_o and imem_wdata_o hold their value when imem_we_o=0.
- Ticks are at least 100 cycles apart at every supported baud rate. A tick coinciding with a write cycle is nevertheless captured normally.
- Command bytes arriving inside a LOAD frame are treated as data, with no decoding.
- step_o and load_done_o are never high for more than 1 cycle.

Decomposition:
- Shared package (existing debug-unit constants file): command byte codes, state encoding (one-hot, same style as the receiver FSM), word width 32.
- One sub-module: uart_word_assembler. Inputs: byte strobe, byte, clear. Outputs: word, word_valid pulse, byte_idx. It holds the byte-lane shift logic.
- FSM, counters and timeout stay in the top module.

Test Plan:
- Reset then byte 0x02 -> run_o=1 one cycle after the tick; byte 0x04 -> run_o=0; all other outputs stay 0.
- LOAD, count 0x0002, bytes 13 00 08 20 / FF FF 09 24 -> writes addr0=0x20080013, addr1=0x2409FFFF. Each write lands 1 cycle after the 4th byte. load_done_o pulses with the second write; busy_o then drops.
- LOAD with count 0x0000 -> no imem_we_o, load_done_o pulse, back to IDLE.
- Byte 0x77 in IDLE -> err_o=1. A following 0x03 with run_o=0 -> err_o=0 and a single step_o pulse. 0x03 while run_o=1 -> no pulse.
- LOAD, count 1, only 2 data bytes, then silence (TIMEOUT_CYCLES set to 50) -> err_o=1 at 50 cycles after the last tick, no write, busy_o=0.
- reset_i asserted after 5 data bytes of a 2-word LOAD -> one write only (addr0). All outputs are 0 the cycle after reset. A fresh LOAD then starts at addr0.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// Debug-unit constants shared by the UART program loader and its word assembler.
// Holds the default command byte codes, the one-hot loader state encoding and
// the instruction word width.
package uart_prog_loader_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  // Default command byte codes
  localparam logic [7:0] CMD_LOAD_DEF = 8'h01;
  localparam logic [7:0] CMD_RUN_DEF  = 8'h02;
  localparam logic [7:0] CMD_STEP_DEF = 8'h03;
  localparam logic [7:0] CMD_HALT_DEF = 8'h04;

  // Loader states, one-hot like the receiver FSM
  localparam int unsigned ST_W = 4;
  localparam logic [ST_W-1:0] S_IDLE   = 4'b0001;
  localparam logic [ST_W-1:0] S_LEN_LO = 4'b0010;
  localparam logic [ST_W-1:0] S_LEN_HI = 4'b0100;
  localparam logic [ST_W-1:0] S_DATA   = 4'b1000;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Bundle between the UART receiver / instruction memory / processor control
// and the program loader.
//   rx_done_tick_i, rx_data_i : receiver byte stream (strobe + byte)
//   imem_we_o/addr_o/wdata_o  : instruction memory write port
//   run_o, step_o             : processor run level and single-step pulse
//   busy_o, load_done_o, err_o: loader status
// master = loader side, slave = environment side.
interface uart_prog_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              rx_done_tick_i;
  logic [7:0]        rx_data_i;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;
  logic              run_o;
  logic              step_o;
  logic              busy_o;
  logic              load_done_o;
  logic              err_o;

  modport master (
    input  rx_done_tick_i, rx_data_i,
    output imem_we_o, imem_addr_o, imem_wdata_o,
    output run_o, step_o, busy_o, load_done_o, err_o
  );

  modport slave (
    output rx_done_tick_i, rx_data_i,
    input  imem_we_o, imem_addr_o, imem_wdata_o,
    input  run_o, step_o, busy_o, load_done_o, err_o
  );
endinterface

// File: rtl/uart_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
//   clock, reset_i : clock and synchronous active-high reset
//   byte_stb_i     : byte_i is valid this cycle
//   byte_i         : incoming byte, first byte lands in bits [7:0]
//   clear_i        : restart at lane 0, discarding any partial word
//   word_o         : last completed word, held between completions
//   word_valid_o   : one-cycle pulse, word_o just updated
//   byte_idx_o     : lane the next byte will fill
module uart_word_assembler
  import uart_prog_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_i,
  input  logic              byte_stb_i,
  input  logic [7:0]        byte_i,
  input  logic              clear_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  output logic [1:0]        byte_idx_o
);

  logic [23:0]       lanes_q, lanes_d;
  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;

  // Lane fill; the word register only changes on the fourth byte so the
  // output stays stable while the next word is being collected.
  always_comb begin
    lanes_d = lanes_q;
    idx_d   = idx_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      idx_d = 2'd0;
    end else if (byte_stb_i) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0: lanes_d[7:0]   = byte_i;
        2'd1: lanes_d[15:8]  = byte_i;
        2'd2: lanes_d[23:16] = byte_i;
        default: begin
          word_d  = {byte_i, lanes_q};
          valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset_i) begin
      lanes_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign byte_idx_o   = idx_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Command sequencer behind the debug UART receiver: decodes one-byte commands,
// loads little-endian program words into instruction memory and drives the
// processor run level / single-step pulse.
//   clock, reset_i : clock and synchronous active-high reset
//   bus            : uart_prog_loader_if master (rx stream in; imem write
//                    port, run/step, busy/load_done/err out)
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter logic [7:0]  CMD_LOAD       = CMD_LOAD_DEF,
  parameter logic [7:0]  CMD_RUN        = CMD_RUN_DEF,
  parameter logic [7:0]  CMD_STEP       = CMD_STEP_DEF,
  parameter logic [7:0]  CMD_HALT       = CMD_HALT_DEF
) (
  input  logic              clock,
  input  logic              reset_i,
  uart_prog_loader_if.master bus
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [ST_W-1:0]   state_q, state_d;
  logic              run_q, run_d;
  logic              step_q, step_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       words_q, words_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic              tick_c;
  logic              asm_stb_c;
  logic              asm_clear_c;
  logic              word_done_c;
  logic              timeout_c;
  logic [WORD_W-1:0] asm_word;
  logic              asm_valid;
  logic [1:0]        asm_idx;

  assign tick_c      = bus.rx_done_tick_i;
  assign asm_stb_c   = tick_c && (state_q == S_DATA);
  assign word_done_c = asm_stb_c && (asm_idx == 2'd3);
  // A tick on the expiring cycle still counts as a byte, not a timeout.
  assign timeout_c   = (state_q != S_IDLE) && !tick_c &&
                       (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));

  uart_word_assembler u_asm (
    .clock        (clock),
    .reset_i      (reset_i),
    .byte_stb_i   (asm_stb_c),
    .byte_i       (bus.rx_data_i),
    .clear_i      (asm_clear_c),
    .word_o       (asm_word),
    .word_valid_o (asm_valid),
    .byte_idx_o   (asm_idx)
  );

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    step_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    addr_d      = addr_q;
    imem_addr_d = imem_addr_q;
    len_lo_d    = len_lo_q;
    words_d     = words_q;
    asm_clear_c = 1'b0;

    // Gap counter is held at 0 in IDLE, which covers the clear on LEN_LO entry.
    if (state_q == S_IDLE || tick_c) gap_d = '0;
    else                             gap_d = gap_q + GAP_W'(1);

    if (timeout_c) begin
      err_d       = 1'b1;
      state_d     = S_IDLE;
      asm_clear_c = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tick_c) begin
            case (bus.rx_data_i)
              CMD_LOAD: begin
                run_d   = 1'b0;
                err_d   = 1'b0;
                state_d = S_LEN_LO;
              end
              CMD_RUN: begin
                run_d = 1'b1;
                err_d = 1'b0;
              end
              CMD_STEP: begin
                step_d = !run_q;
                err_d  = 1'b0;
              end
              CMD_HALT: begin
                run_d = 1'b0;
                err_d = 1'b0;
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        S_LEN_LO: begin
          if (tick_c) begin
            len_lo_d = bus.rx_data_i;
            state_d  = S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (tick_c) begin
            words_d     = {bus.rx_data_i, len_lo_q};
            addr_d      = '0;
            asm_clear_c = 1'b1;
            if ({bus.rx_data_i, len_lo_q} == 16'd0) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          // The write itself is issued by the assembler's registered outputs.
          if (word_done_c) begin
            imem_addr_d = addr_q;
            addr_d      = addr_q + ADDR_W'(1);
            words_d     = words_q - 16'd1;
            if (words_q == 16'd1) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      imem_addr_q <= '0;
      len_lo_q    <= '0;
      words_q     <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      step_q      <= step_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      imem_addr_q <= imem_addr_d;
      len_lo_q    <= len_lo_d;
      words_q     <= words_d;
      gap_q       <= gap_d;
    end
  end

  assign bus.imem_we_o    = asm_valid;
  assign bus.imem_addr_o  = imem_addr_q;
  assign bus.imem_wdata_o = asm_word;
  assign bus.run_o        = run_q;
  assign bus.step_o       = step_q;
  assign bus.busy_o       = busy_q;
  assign bus.load_done_o  = done_q;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with hand-computed expectations.
module tb_uart_prog_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   we_cnt   = 0;
  int   done_cnt = 0;
  int   step_cnt = 0;
  int   w0, d0, s0;

  uart_prog_loader_if #(.ADDR_W(10)) bus ();

  uart_prog_loader #(.ADDR_W(10), .TIMEOUT_CYCLES(50)) dut (
    .clock   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      we_cnt   <= we_cnt + int'(bus.imem_we_o);
      done_cnt <= done_cnt + int'(bus.load_done_o);
      step_cnt <= step_cnt + int'(bus.step_o);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One tick per call; returns at the negedge right after the sampling edge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data_i      = b;
    bus.rx_done_tick_i = 1'b1;
    @(negedge clk);
    bus.rx_done_tick_i = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.imem_we_o, bus.imem_addr_o, bus.imem_wdata_o, bus.run_o,
                bus.step_o, bus.busy_o, bus.load_done_o, bus.err_o});
  endfunction

  initial begin
    bus.rx_done_tick_i = 1'b0;
    bus.rx_data_i      = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", all_outs(), 64'h0);
    rst = 1'b0;

    // RUN / HALT
    send_byte(8'h02);
    check_eq("run_set", 64'(bus.run_o), 64'h1);
    check_eq("run_side", 64'({bus.step_o, bus.busy_o, bus.err_o, bus.imem_we_o}), 64'h0);
    send_byte(8'h04);
    check_eq("halt_clr", 64'(bus.run_o), 64'h0);

    // Two-word LOAD; LOAD also drops run
    send_byte(8'h02);
    send_byte(8'h01);
    check_eq("load_run0", 64'(bus.run_o), 64'h0);
    check_eq("load_busy", 64'(bus.busy_o), 64'h1);
    send_byte(8'h02);
    send_byte(8'h00);
    check_eq("len_busy", 64'(bus.busy_o), 64'h1);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h08);
    check_eq("w0_nowe", 64'(bus.imem_we_o), 64'h0);
    send_byte(8'h20);
    check_eq("w0_we", 64'(bus.imem_we_o), 64'h1);
    check_eq("w0_addr", 64'(bus.imem_addr_o), 64'h0);
    check_eq("w0_data", 64'(bus.imem_wdata_o), 64'h20080013);
    check_eq("w0_nodone", 64'(bus.load_done_o), 64'h0);
    @(negedge clk);
    check_eq("w0_we_pulse", 64'(bus.imem_we_o), 64'h0);
    check_eq("w0_data_hold", 64'(bus.imem_wdata_o), 64'h20080013);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h09);
    send_byte(8'h24);
    check_eq("w1_we", 64'(bus.imem_we_o), 64'h1);
    check_eq("w1_addr", 64'(bus.imem_addr_o), 64'h1);
    check_eq("w1_data", 64'(bus.imem_wdata_o), 64'h2409FFFF);
    check_eq("w1_done", 64'(bus.load_done_o), 64'h1);
    check_eq("w1_busy", 64'(bus.busy_o), 64'h0);
    @(negedge clk);
    check_eq("done_pulse", 64'({bus.load_done_o, bus.imem_we_o}), 64'h0);
    check_eq("w1_addr_hold", 64'(bus.imem_addr_o), 64'h1);
    check_eq("load2_we_cnt", 64'(we_cnt), 64'd2);

    // Zero-length LOAD
    w0 = we_cnt;
    d0 = done_cnt;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    check_eq("zero_done", 64'(bus.load_done_o), 64'h1);
    check_eq("zero_busy", 64'(bus.busy_o), 64'h0);
    repeat (3) @(negedge clk);
    check_eq("zero_nowrite", 64'(we_cnt - w0), 64'h0);
    check_eq("zero_done_cnt", 64'(done_cnt - d0), 64'h1);

    // Bad command, STEP when halted, STEP when running
    send_byte(8'h77);
    check_eq("bad_err", 64'(bus.err_o), 64'h1);
    s0 = step_cnt;
    send_byte(8'h03);
    check_eq("step_errclr", 64'(bus.err_o), 64'h0);
    check_eq("step_pulse", 64'(bus.step_o), 64'h1);
    @(negedge clk);
    check_eq("step_width", 64'(bus.step_o), 64'h0);
    check_eq("step_cnt", 64'(step_cnt - s0), 64'h1);
    send_byte(8'h02);
    s0 = step_cnt;
    send_byte(8'h03);
    repeat (3) @(negedge clk);
    check_eq("step_ignored", 64'(step_cnt - s0), 64'h0);
    send_byte(8'h04);

    // Timeout: count 1, two data bytes, then silence
    w0 = we_cnt;
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAB);
    send_byte(8'hCD);
    repeat (49) @(negedge clk);
    check_eq("to_early_err", 64'(bus.err_o), 64'h0);
    check_eq("to_early_busy", 64'(bus.busy_o), 64'h1);
    @(negedge clk);
    check_eq("to_err", 64'(bus.err_o), 64'h1);
    check_eq("to_busy", 64'(bus.busy_o), 64'h0);
    check_eq("to_nowrite", 64'(we_cnt - w0), 64'h0);

    // Reset in the middle of a two-word LOAD
    w0 = we_cnt;
    send_byte(8'h01);
    check_eq("load_errclr", 64'(bus.err_o), 64'h0);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    check_eq("rs_w0_data", 64'(bus.imem_wdata_o), 64'h44332211);
    send_byte(8'h55);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rs_outs", all_outs(), 64'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rs_one_write", 64'(we_cnt - w0), 64'h1);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    check_eq("rs_new_we", 64'(bus.imem_we_o), 64'h1);
    check_eq("rs_new_addr", 64'(bus.imem_addr_o), 64'h0);
    check_eq("rs_new_data", 64'(bus.imem_wdata_o), 64'hEFBEADDE);
    check_eq("rs_new_done", 64'(bus.load_done_o), 64'h1);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
